rx_link_layer: RTL and testbench

RX_LINK_LAYER -- requirements
Module: rx_link_layer

---
 rtl/rx_link_layer_pkg.sv | 20 ++
 rtl/decoder_8b10b.sv | 106 ++++++++++
 rtl/jesd204b_defs.vh | 11 +
 rtl/rx_link_layer.sv | 113 +++++++++++
 tb/tb_rx_link_layer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/rx_link_layer_pkg.sv
// rx_link_layer_pkg: CGS state type, decoded-character record and counter sizing.
`include "jesd204b_defs.vh"
package rx_link_layer_pkg;
  typedef enum logic [1:0] {
    CS_INIT  = `CGS_INIT,
    CS_CHECK = `CGS_CHECK,
    CS_DATA  = `CGS_DATA
  } cgs_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       disp_err;
    logic       nit_err;
  } dec_char_t;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/decoder_8b10b.sv
// decoder_8b10b: 10b->8b decode with running-disparity tracking; outputs registered once.
// i_data is abcdei_fghj with a in bit 9; decoded data is HGFEDCBA.
module decoder_8b10b
  import rx_link_layer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_data,
  output dec_char_t  o_char
);
  // {valid, EDCBA}; both disparity columns map to the same value
  function automatic logic [5:0] dec6(input logic [5:0] c);
    case (c)
      6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
      6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
      6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
      6'b110001:            dec6 = {1'b1, 5'd3};
      6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
      6'b101001:            dec6 = {1'b1, 5'd5};
      6'b011001:            dec6 = {1'b1, 5'd6};
      6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
      6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
      6'b100101:            dec6 = {1'b1, 5'd9};
      6'b010101:            dec6 = {1'b1, 5'd10};
      6'b110100:            dec6 = {1'b1, 5'd11};
      6'b001101:            dec6 = {1'b1, 5'd12};
      6'b101100:            dec6 = {1'b1, 5'd13};
      6'b011100:            dec6 = {1'b1, 5'd14};
      6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
      6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
      6'b100011:            dec6 = {1'b1, 5'd17};
      6'b010011:            dec6 = {1'b1, 5'd18};
      6'b110010:            dec6 = {1'b1, 5'd19};
      6'b001011:            dec6 = {1'b1, 5'd20};
      6'b101010:            dec6 = {1'b1, 5'd21};
      6'b011010:            dec6 = {1'b1, 5'd22};
      6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
      6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
      6'b100110:            dec6 = {1'b1, 5'd25};
      6'b010110:            dec6 = {1'b1, 5'd26};
      6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
      6'b001110:            dec6 = {1'b1, 5'd28};
      6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
      6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
      6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
      6'b001111, 6'b110000: dec6 = {1'b1, 5'd28};
      default:              dec6 = 6'd0;
    endcase
  endfunction

  // {valid, HGF}; includes the alternate x.7 form
  function automatic logic [3:0] dec4(input logic [3:0] c);
    case (c)
      4'b1011, 4'b0100:                   dec4 = {1'b1, 3'd0};
      4'b1001:                            dec4 = {1'b1, 3'd1};
      4'b0101:                            dec4 = {1'b1, 3'd2};
      4'b1100, 4'b0011:                   dec4 = {1'b1, 3'd3};
      4'b1101, 4'b0010:                   dec4 = {1'b1, 3'd4};
      4'b1010:                            dec4 = {1'b1, 3'd5};
      4'b0110:                            dec4 = {1'b1, 3'd6};
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
      default:                            dec4 = 4'd0;
    endcase
  endfunction

  logic       rd_q, rd_d, rd6;
  dec_char_t  char_q, char_d;
  logic [5:0] c6, d6;
  logic [3:0] c4, d4;
  logic [2:0] n6, n4;
  logic       k28, k_alt, a7, a7_ok;

  always_comb begin
    c6     = i_data[9:4];
    c4     = i_data[3:0];
    n6     = 3'($countones(c6));
    n4     = 3'($countones(c4));
    k28    = c6 == 6'b001111 || c6 == 6'b110000;
    d6     = dec6(c6);
    d4     = dec4(c6 == 6'b110000 ? ~c4 : c4);
    a7     = c4 == 4'b0111 || c4 == 4'b1000;
    k_alt  = a7 && !k28 && (d6[4:0] inside {5'd23, 5'd27, 5'd29, 5'd30});
    a7_ok  = k28 || k_alt || (d6[4:0] inside {5'd11, 5'd13, 5'd14, 5'd17, 5'd18, 5'd20});
    rd6    = n6 > 3'd3 ? 1'b1 : n6 < 3'd3 ? 1'b0 : rd_q;
    rd_d   = n4 > 3'd2 ? 1'b1 : n4 < 3'd2 ? 1'b0 : rd6;
    char_d.data     = {d4[2:0], d6[4:0]};
    char_d.k        = k28 || k_alt;
    char_d.nit_err  = !d6[5] || !d4[3] || (a7 && !a7_ok);
    char_d.disp_err = (n6 == 3'd4 && rd_q) || (n6 == 3'd2 && !rd_q) ||
                      (c6 == 6'b111000 && rd_q) || (c6 == 6'b000111 && !rd_q) ||
                      (n4 == 3'd3 && rd6) || (n4 == 3'd1 && !rd6) ||
                      (c4 == 4'b1100 && rd6) || (c4 == 4'b0011 && !rd6);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= 1'b0;
      char_q <= '0;
    end else begin
      rd_q   <= rd_d;
      char_q <= char_d;
    end
  end

  assign o_char = char_q;
endmodule

// File: rtl/jesd204b_defs.vh
// jesd204b_defs.vh: shared JESD204B control characters and CGS state encodings.
`ifndef JESD204B_DEFS_VH
`define JESD204B_DEFS_VH
`define K28_5 8'hBC
`define K28_0 8'h1C
`define K28_3 8'h7C
`define K28_7 8'hFC
`define CGS_INIT 2'd0
`define CGS_CHECK 2'd1
`define CGS_DATA 2'd2
`endif

// File: rtl/rx_link_layer.sv
// rx_link_layer: JESD204B receive code-group sync FSM behind an 8b/10b decoder, 2-cycle latency.
// RX_ERR_CNT_EN adds a saturating errored-character counter on o_err_cnt.
`include "jesd204b_defs.vh"
module rx_link_layer
  import rx_link_layer_pkg::*;
#(
  parameter int K_CNT      = 4,
  parameter int ERR_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  i_data,
  input  logic        i_resync,
  output logic [7:0]  o_data,
  output logic        o_k,
  output logic        o_vld,
  output logic        o_sync_n,
  output logic        o_ilas_start,
  output logic        o_disp_err,
  output logic        o_nit_err,
  output logic [1:0]  o_cgs_state,
  output logic [15:0] o_err_cnt
);
  localparam int CW = cnt_width(K_CNT, ERR_THRESH);

  dec_char_t     dc, out_q, out_d;
  cgs_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          err, k285, ilas_hit;
  logic          ilas_seen_q, ilas_seen_d;
  logic          vld_q, vld_d, ilas_q, ilas_d;

  decoder_8b10b u_dec (
    .clk    (clk),
    .rst    (rst),
    .i_data (i_data),
    .o_char (dc)
  );

  // One counter serves both states: good /K/ run in CHECK, errored run in DATA
  always_comb begin
    err      = dc.disp_err | dc.nit_err;
    k285     = dc.k && dc.data == `K28_5 && !err;
    ilas_hit = state_q == CS_DATA && dc.k && dc.data == `K28_0 && !err && !ilas_seen_q;
    cnt_inc  = cnt_q + CW'(1);
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      CS_INIT, CS_CHECK: begin
        state_d = !k285 ? CS_INIT : cnt_inc == CW'(K_CNT) ? CS_DATA : CS_CHECK;
        cnt_d   = state_d == CS_CHECK ? cnt_inc : '0;
      end
      CS_DATA: begin
        state_d = err && cnt_inc == CW'(ERR_THRESH) ? CS_INIT : CS_DATA;
        cnt_d   = err && state_d == CS_DATA ? cnt_inc : '0;
      end
      default: begin
        state_d = CS_INIT;
        cnt_d   = '0;
      end
    endcase
    if (i_resync) begin
      state_d = CS_INIT;
      cnt_d   = '0;
    end
    out_d       = dc;
    vld_d       = state_q == CS_DATA;
    ilas_d      = ilas_hit;
    ilas_seen_d = state_q == CS_DATA && (ilas_seen_q || ilas_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CS_INIT;
      cnt_q       <= '0;
      ilas_seen_q <= 1'b0;
      out_q       <= '0;
      vld_q       <= 1'b0;
      ilas_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ilas_seen_q <= ilas_seen_d;
      out_q       <= out_d;
      vld_q       <= vld_d;
      ilas_q      <= ilas_d;
    end
  end

  assign o_data       = out_q.data;
  assign o_k          = out_q.k;
  assign o_disp_err   = out_q.disp_err;
  assign o_nit_err    = out_q.nit_err;
  assign o_vld        = vld_q;
  assign o_ilas_start = ilas_q;
  assign o_cgs_state  = state_q;
  assign o_sync_n     = state_q == CS_DATA;

`ifdef RX_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb err_cnt_d = err && err_cnt_q != 16'hFFFF ? err_cnt_q + 16'd1 : err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign o_err_cnt = err_cnt_q;
`else
  assign o_err_cnt = '0;
`endif
endmodule

// File: tb/tb_rx_link_layer.sv
// tb_rx_link_layer: directed checks of decode, CGS sync, ILAS pulse, error resync and reset.
module tb_rx_link_layer;
  localparam logic [9:0] K285_N = 10'b0011111010;
  localparam logic [9:0] K285_P = 10'b1100000101;
  localparam logic [9:0] K280_N = 10'b0011110100;
  localparam logic [9:0] K280_P = 10'b1100001011;
  localparam logic [9:0] D000_N = 10'b1001110100;
  localparam logic [9:0] D000_P = 10'b0110001011;
  localparam logic [9:0] D215   = 10'b1010101010;
  localparam logic [9:0] BAD    = 10'b1111111111;
`ifdef RX_ERR_CNT_EN
  localparam logic [15:0] EXP_ERR = 16'd7;
`else
  localparam logic [15:0] EXP_ERR = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_resync = 1'b0;
  logic [9:0]  i_data = D215;
  logic [7:0]  o_data;
  logic        o_k, o_vld, o_sync_n, o_ilas_start, o_disp_err, o_nit_err;
  logic [1:0]  o_cgs_state;
  logic [15:0] o_err_cnt;
  logic        rd = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [1:0]  exp_rtn [9] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};

  always #5 clk = ~clk;

  rx_link_layer dut (
    .clk          (clk),
    .rst          (rst),
    .i_data       (i_data),
    .i_resync     (i_resync),
    .o_data       (o_data),
    .o_k          (o_k),
    .o_vld        (o_vld),
    .o_sync_n     (o_sync_n),
    .o_ilas_start (o_ilas_start),
    .o_disp_err   (o_disp_err),
    .o_nit_err    (o_nit_err),
    .o_cgs_state  (o_cgs_state),
    .o_err_cnt    (o_err_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input logic [9:0] c);
    i_data = c;
    @(posedge clk);
    #1;
  endtask

  task automatic k285();
    tick(rd ? K285_P : K285_N);
    rd = !rd;
  endtask

  task automatic lock();
    repeat (4) k285();
    tick(D215);
    chk("lock_state", 16'(o_cgs_state), 16'd2);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 16'(o_cgs_state), 16'd0);
    chk("rst_sync_n", 16'(o_sync_n), 16'd0);
    chk("rst_vld", 16'(o_vld), 16'd0);
    chk("rst_data", 16'(o_data), 16'd0);
    chk("rst_ilas", 16'(o_ilas_start), 16'd0);
    chk("rst_err_cnt", o_err_cnt, 16'd0);
    rst = 1'b0;
    k285();
    chk("init_state", 16'(o_cgs_state), 16'd0);
    k285();
    chk("check_state", 16'(o_cgs_state), 16'd1);
    k285();
    k285();
    chk("sync_before", 16'(o_sync_n), 16'd0);
    tick(D215);
    chk("data_state", 16'(o_cgs_state), 16'd2);
    chk("sync_rise", 16'(o_sync_n), 16'd1);
    chk("vld_last_k", 16'(o_vld), 16'd0);
    chk("k285_data", 16'(o_data), 16'hBC);
    chk("k285_k", 16'(o_k), 16'd1);
    tick(D215);
    chk("vld_data", 16'(o_vld), 16'd1);
    chk("d215_data", 16'(o_data), 16'hB5);
    chk("d215_k", 16'(o_k), 16'd0);
    tick(rd ? K280_P : K280_N);
    tick(rd ? D000_P : D000_N);
    chk("ilas_first", 16'(o_ilas_start), 16'd1);
    chk("k280_vld", 16'(o_vld), 16'd1);
    chk("k280_k", 16'(o_k), 16'd1);
    chk("k280_data", 16'(o_data), 16'h1C);
    tick(rd ? K280_P : K280_N);
    chk("ilas_d00", 16'(o_ilas_start), 16'd0);
    chk("d00_data", 16'(o_data), 16'h00);
    chk("d00_k", 16'(o_k), 16'd0);
    tick(D215);
    chk("ilas_second", 16'(o_ilas_start), 16'd0);
    chk("k280b_data", 16'(o_data), 16'h1C);
    i_resync = 1'b1;
    tick(D215);
    i_resync = 1'b0;
    chk("resync_state", 16'(o_cgs_state), 16'd0);
    chk("resync_sync_n", 16'(o_sync_n), 16'd0);
    lock();
    repeat (3) tick(rd ? K285_N : K285_P);
    tick(D215);
    chk("err3_state", 16'(o_cgs_state), 16'd2);
    chk("err3_disp", 16'(o_disp_err), 16'd1);
    chk("err3_nit", 16'(o_nit_err), 16'd0);
    tick(rd ? K285_N : K285_P);
    chk("good_disp", 16'(o_disp_err), 16'd0);
    repeat (3) tick(rd ? K285_N : K285_P);
    chk("err_pre_state", 16'(o_cgs_state), 16'd2);
    tick(D215);
    chk("err4_state", 16'(o_cgs_state), 16'd0);
    chk("err4_sync_n", 16'(o_sync_n), 16'd0);
    chk("err_cnt", o_err_cnt, EXP_ERR);
    for (int i = 0; i < 9; i++) begin
      if (i == 3 || i == 8) tick(D215);
      else k285();
      chk("rtn_state", 16'(o_cgs_state), 16'(exp_rtn[i]));
      chk("rtn_vld", 16'(o_vld), 16'd0);
    end
    tick(D215);
    chk("rtn_vld_data", 16'(o_vld), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_sync_n", 16'(o_sync_n), 16'd0);
    chk("async_vld", 16'(o_vld), 16'd0);
    chk("async_state", 16'(o_cgs_state), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd = 1'b0;
    tick(D000_N);
    tick(D215);
    chk("rd_reset_data", 16'(o_data), 16'h00);
    chk("rd_reset_disp", 16'(o_disp_err), 16'd0);
    chk("rd_reset_nit", 16'(o_nit_err), 16'd0);
    chk("rd_reset_cnt", o_err_cnt, 16'd0);
    tick(BAD);
    tick(D215);
    chk("nit_bad", 16'(o_nit_err), 16'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
